// File: rtl/apb_pkg.sv
// Shared types and constant helpers for the APB command arbiter and its picker.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        WAIT = 2'b10
    } arb_state_e;

    // Command layout is {pwrite, addr, wdata}; pwrite is the top bit.
    function automatic int cmd_bw(input int data_bw, input int addr_bw);
        return data_bw + addr_bw + 1;
    endfunction

    function automatic int pwrite_idx(input int cmd_w);
        return cmd_w - 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb_cmd_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_vld_o
);

    int              pos;
    logic [IDXW-1:0] pos_idx;

    always_comb begin
        gnt_o     = '0;
        idx_o     = '0;
        any_vld_o = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            pos_idx = pos[IDXW-1:0];
            if (!any_vld_o && req_i[pos_idx]) begin
                any_vld_o      = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_arb.sv
// Round-robin arbiter sharing one apb_tx command port among NUM_REQ requesters.
// Define APB_ARB_WR_ACK_EN to get a response pulse (rsp_data=0) on write completion.
module apb_cmd_arb
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_BW = 8,
    parameter int ADDR_BW = 8,
    parameter int CMD_BW  = cmd_bw(DATA_BW, ADDR_BW)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*CMD_BW-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]        req_vld,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_BW-1:0]        rsp_data,
    output logic [CMD_BW-1:0]         m_cmd,
    output logic                      m_cmd_vld,
    input  logic                      m_cmd_rdy,
    input  logic [DATA_BW-1:0]        m_read_data,
    input  logic                      m_read_vld
);

    localparam int IDXW = clog2(NUM_REQ);
`ifdef APB_ARB_WR_ACK_EN
    localparam int PWRITE_BIT = pwrite_idx(CMD_BW);
`endif

    arb_state_e          state_q, state_d;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]     owner_q, owner_d;
    logic [CMD_BW-1:0]   cmd_q, cmd_d;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic [DATA_BW-1:0]  rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]  pick_gnt, owner_oh;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_any;

    rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i     (req_vld),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .any_vld_o (pick_any)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign m_cmd    = cmd_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        req_rdy    = '0;
        m_cmd_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = pick_gnt;
                if (pick_any) begin
                    cmd_d   = req_cmd[int'(pick_idx)*CMD_BW +: CMD_BW];
                    owner_d = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                m_cmd_vld = 1'b1;
                if (m_cmd_rdy) state_d = WAIT;
            end
            WAIT: begin
                // apb_tx keeps m_cmd_rdy low through SEL/ACCE; its return marks completion.
                if (m_read_vld) begin
                    rsp_vld_d  = owner_oh;
                    rsp_data_d = m_read_data;
                end
                if (m_cmd_rdy) begin
                    rr_ptr_d = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = IDLE;
`ifdef APB_ARB_WR_ACK_EN
                    if (cmd_q[PWRITE_BIT]) begin
                        rsp_vld_d  = owner_oh;
                        rsp_data_d = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cmd_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_arb.sv
// Directed bench for apb_cmd_arb with a behavioural apb_tx model and a grant/fire/response logger.
`timescale 1ns/1ps
module tb_apb_cmd_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 17;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR*CW-1:0] req_cmd = '0;
    logic [NR-1:0]    req_vld = '0;
    logic [NR-1:0]    req_rdy;
    logic [NR-1:0]    rsp_vld;
    logic [DW-1:0]    rsp_data;
    logic [CW-1:0]    m_cmd;
    logic             m_cmd_vld;
    logic             m_cmd_rdy = 1'b1;
    logic [DW-1:0]    m_read_data = '0;
    logic             m_read_vld = 1'b0;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;

    int            gnt_q[$];
    int            gnt_cyc_q[$];
    int            gnt_ptr_q[$];
    int            fire_cyc_q[$];
    logic [CW-1:0] fire_cmd_q[$];
    logic [NR-1:0] rsp_vld_q[$];
    logic [DW-1:0] rsp_data_q[$];
    logic [NR-1:0] hold_mask = '0;
    logic [NR-1:0] drop_pend = '0;
    int            overlap_cnt = 0;

    int            slv_wait = 0;
    int            slv_hold = 0;
    logic [DW-1:0] slv_rdata = '0;
    int            sph = 0;
    int            scnt = 0;
    logic          s_wr = 1'b0;

    apb_cmd_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_cmd     (req_cmd),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .m_cmd       (m_cmd),
        .m_cmd_vld   (m_cmd_vld),
        .m_cmd_rdy   (m_cmd_rdy),
        .m_read_data (m_read_data),
        .m_read_vld  (m_read_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // apb_tx model: ready while idle, then SEL, ACCE (+slv_wait), ready again.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sph = 0; m_cmd_rdy = 1'b1; m_read_vld = 1'b0;
            end else begin
                case (sph)
                    0: begin
                        m_read_vld = 1'b0;
                        if (slv_hold > 0) begin
                            m_cmd_rdy = 1'b0;
                            if (m_cmd_vld) slv_hold--;
                        end else begin
                            m_cmd_rdy = 1'b1;
                            if (m_cmd_vld) begin sph = 1; s_wr = m_cmd[CW-1]; end
                        end
                    end
                    1: begin m_cmd_rdy = 1'b0; scnt = slv_wait; sph = 2; end
                    default: begin
                        m_cmd_rdy = 1'b0;
                        if (scnt > 0) scnt--;
                        else begin
                            m_read_vld = !s_wr; m_read_data = slv_rdata; sph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Logger; granted requesters outside hold_mask drop req_vld after the accept edge.
    initial begin
        forever begin
            @(negedge clk);
            if (drop_pend != '0) begin req_vld = req_vld & ~drop_pend; drop_pend = '0; end
            #2;
            if (rst_n) begin
                if (req_rdy != '0) begin
                    if (!$onehot(req_rdy)) overlap_cnt++;
                    for (int i = 0; i < NR; i++) if (req_rdy[i]) begin
                        gnt_q.push_back(i);
                        gnt_cyc_q.push_back(cyc);
                        gnt_ptr_q.push_back(int'(dut.rr_ptr_q));
                        if (!hold_mask[i]) drop_pend[i] = 1'b1;
                    end
                end
                if (m_cmd_vld && m_cmd_rdy) begin
                    fire_cyc_q.push_back(cyc);
                    fire_cmd_q.push_back(m_cmd);
                end
                if (rsp_vld != '0) begin
                    rsp_vld_q.push_back(rsp_vld);
                    rsp_data_q.push_back(rsp_data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_logs();
        gnt_q.delete(); gnt_cyc_q.delete(); gnt_ptr_q.delete();
        fire_cyc_q.delete(); fire_cmd_q.delete();
        rsp_vld_q.delete(); rsp_data_q.delete();
        overlap_cnt = 0;
    endtask

    task automatic set_cmd(input int i, input logic [CW-1:0] c);
        req_cmd[i*CW +: CW] = c;
    endtask

    task automatic wait_gnts(input int n, input int budget);
        for (int t = 0; t < budget && gnt_q.size() < n; t++) tick();
    endtask

    task automatic wait_fires(input int n, input int budget);
        for (int t = 0; t < budget && fire_cyc_q.size() < n; t++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; req_cmd = '0;
        repeat (3) tick();
        chk_cnt++; if (m_cmd_vld !== 1'b0) $display("FAIL rst_m_cmd_vld got %b want 0", m_cmd_vld); else pass_cnt++;
        chk_cnt++; if (m_cmd !== 17'h0) $display("FAIL rst_m_cmd got %h want 0", m_cmd); else pass_cnt++;
        chk_cnt++; if (req_rdy !== 4'b0) $display("FAIL rst_req_rdy got %b want 0000", req_rdy); else pass_cnt++;
        chk_cnt++; if (rsp_vld !== 4'b0) $display("FAIL rst_rsp_vld got %b want 0000", rsp_vld); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'h0) $display("FAIL rst_rsp_data got %h want 00", rsp_data); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        clear_logs(); slv_wait = 0; hold_mask = 4'b1111;
        for (int i = 0; i < NR; i++) set_cmd(i, {1'b0, 8'(8'h10 + i), 8'h00});
        req_vld = 4'b1111;
        wait_gnts(8, 100);
        req_vld = '0; hold_mask = '0;
        repeat (10) tick();
        chk_cnt++; if (gnt_q.size() !== 8) $display("FAIL fair_count got %0d want 8", gnt_q.size()); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            chk_cnt++;
            if (gnt_q[k] !== k % 4) $display("FAIL fair_order[%0d] got %0d want %0d", k, gnt_q[k], k % 4);
            else pass_cnt++;
        end
        chk_cnt++; if (overlap_cnt !== 0) $display("FAIL fair_overlap got %0d want 0", overlap_cnt); else pass_cnt++;
    endtask

    task automatic test_single_read();
        clear_logs(); slv_wait = 2; slv_rdata = 8'hA5;
        set_cmd(1, {1'b0, 8'h3C, 8'h00});
        req_vld = 4'b0010;
        wait_gnts(1, 20);
        wait_fires(1, 20);
        repeat (12) tick();
        chk_cnt++; if (gnt_q.size() !== 1 || gnt_q[0] !== 1) $display("FAIL rd_grant got %0d want 1", gnt_q[0]); else pass_cnt++;
        chk_cnt++; if (fire_cmd_q[0] !== 17'h03C00) $display("FAIL rd_m_cmd got %h want 03c00", fire_cmd_q[0]); else pass_cnt++;
        chk_cnt++; if (fire_cyc_q[0] - gnt_cyc_q[0] !== 1) $display("FAIL rd_latency got %0d want 1", fire_cyc_q[0] - gnt_cyc_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q.size() !== 1) $display("FAIL rd_rsp_count got %0d want 1", rsp_vld_q.size()); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q[0] !== 4'b0010) $display("FAIL rd_rsp_vld got %b want 0010", rsp_vld_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_data_q[0] !== 8'hA5) $display("FAIL rd_rsp_data got %h want a5", rsp_data_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'hA5 || rsp_vld !== 4'b0) $display("FAIL rd_hold got %h/%b want a5/0000", rsp_data, rsp_vld); else pass_cnt++;
    endtask

    task automatic test_write_then_wait();
        clear_logs(); slv_wait = 1; slv_rdata = 8'h77;
        set_cmd(2, {1'b1, 8'h10, 8'h5A});
        set_cmd(0, {1'b0, 8'h20, 8'h00});
        req_vld = 4'b0101;
        wait_gnts(2, 60);
        repeat (12) tick();
        chk_cnt++; if (gnt_q[0] !== 2) $display("FAIL wr_first_grant got %0d want 2", gnt_q[0]); else pass_cnt++;
        chk_cnt++; if (gnt_q[1] !== 0) $display("FAIL wr_next_grant got %0d want 0", gnt_q[1]); else pass_cnt++;
        chk_cnt++; if (gnt_ptr_q[1] !== 3) $display("FAIL wr_rr_ptr got %0d want 3", gnt_ptr_q[1]); else pass_cnt++;
        chk_cnt++; if (fire_cmd_q[0] !== 17'h1105A) $display("FAIL wr_m_cmd got %h want 1105a", fire_cmd_q[0]); else pass_cnt++;
        chk_cnt++; if (fire_cmd_q[1] !== 17'h02000) $display("FAIL wr_rd_m_cmd got %h want 02000", fire_cmd_q[1]); else pass_cnt++;
`ifdef APB_ARB_WR_ACK_EN
        chk_cnt++; if (rsp_vld_q.size() !== 2) $display("FAIL wr_rsp_count got %0d want 2", rsp_vld_q.size()); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q[0] !== 4'b0100 || rsp_data_q[0] !== 8'h00) $display("FAIL wr_ack got %b/%h want 0100/00", rsp_vld_q[0], rsp_data_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q[1] !== 4'b0001 || rsp_data_q[1] !== 8'h77) $display("FAIL wr_rd_rsp got %b/%h want 0001/77", rsp_vld_q[1], rsp_data_q[1]); else pass_cnt++;
`else
        chk_cnt++; if (rsp_vld_q.size() !== 1) $display("FAIL wr_rsp_count got %0d want 1", rsp_vld_q.size()); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q[0] !== 4'b0001 || rsp_data_q[0] !== 8'h77) $display("FAIL wr_rd_rsp got %b/%h want 0001/77", rsp_vld_q[0], rsp_data_q[0]); else pass_cnt++;
`endif
    endtask

    task automatic test_wr_ack();
        clear_logs(); slv_wait = 0;
        set_cmd(1, {1'b1, 8'h44, 8'h99});
        req_vld = 4'b0010;
        wait_gnts(1, 20);
        repeat (10) tick();
        chk_cnt++; if (gnt_q[0] !== 1) $display("FAIL ack_grant got %0d want 1", gnt_q[0]); else pass_cnt++;
`ifdef APB_ARB_WR_ACK_EN
        chk_cnt++; if (rsp_vld_q.size() !== 1) $display("FAIL ack_count got %0d want 1", rsp_vld_q.size()); else pass_cnt++;
        chk_cnt++; if (rsp_vld_q[0] !== 4'b0010) $display("FAIL ack_vld got %b want 0010", rsp_vld_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'h00) $display("FAIL ack_data got %h want 00", rsp_data); else pass_cnt++;
`else
        chk_cnt++; if (rsp_vld_q.size() !== 0) $display("FAIL ack_count got %0d want 0", rsp_vld_q.size()); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'h77) $display("FAIL ack_data_hold got %h want 77", rsp_data); else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        clear_logs(); slv_wait = 0; slv_rdata = 8'h5C; hold_mask = 4'b0011;
        set_cmd(0, {1'b0, 8'h01, 8'h00});
        set_cmd(1, {1'b0, 8'h02, 8'h00});
        req_vld = 4'b0011;
        wait_fires(3, 60);
        req_vld = '0; hold_mask = '0;
        repeat (10) tick();
        chk_cnt++; if (fire_cyc_q.size() !== 3) $display("FAIL b2b_fires got %0d want 3", fire_cyc_q.size()); else pass_cnt++;
        chk_cnt++; if (fire_cyc_q[1] - fire_cyc_q[0] !== 5) $display("FAIL b2b_gap0 got %0d want 5", fire_cyc_q[1] - fire_cyc_q[0]); else pass_cnt++;
        chk_cnt++; if (fire_cyc_q[2] - fire_cyc_q[1] !== 5) $display("FAIL b2b_gap1 got %0d want 5", fire_cyc_q[2] - fire_cyc_q[1]); else pass_cnt++;
        chk_cnt++; if (gnt_q[0] !== 0 || gnt_q[1] !== 1 || gnt_q[2] !== 0) $display("FAIL b2b_order got %0d,%0d,%0d want 0,1,0", gnt_q[0], gnt_q[1], gnt_q[2]); else pass_cnt++;
    endtask

    task automatic test_hold_low();
        int bad;
        bad = 0;
        clear_logs(); slv_wait = 0; slv_rdata = 8'h3E; slv_hold = 10;
        set_cmd(3, {1'b0, 8'hAB, 8'hCD});
        tick();
        req_vld = 4'b1000;
        for (int t = 0; t < 20; t++) begin tick(); if (m_cmd_vld) break; end
        for (int k = 0; k < 10; k++) begin
            if (m_cmd !== 17'h0ABCD || m_cmd_vld !== 1'b1) bad++;
            tick();
        end
        wait_fires(1, 20);
        repeat (10) tick();
        chk_cnt++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (fire_cyc_q[0] - gnt_cyc_q[0] !== 11) $display("FAIL hold_fire_delay got %0d want 11", fire_cyc_q[0] - gnt_cyc_q[0]); else pass_cnt++;
        chk_cnt++; if (fire_cmd_q[0] !== 17'h0ABCD) $display("FAIL hold_m_cmd got %h want 0abcd", fire_cmd_q[0]); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'h3E) $display("FAIL hold_rsp_data got %h want 3e", rsp_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_logs(); slv_wait = 2; slv_rdata = 8'hEE;
        set_cmd(3, {1'b0, 8'hC3, 8'h00});
        req_vld = 4'b1000;
        wait_fires(1, 30);
        tick();
        rst_n = 1'b0; req_vld = '0;
        #1;
        chk_cnt++; if (fire_cyc_q.size() !== 1) $display("FAIL rm_fired got %0d want 1", fire_cyc_q.size()); else pass_cnt++;
        chk_cnt++; if (m_cmd_vld !== 1'b0 || m_cmd !== 17'h0) $display("FAIL rm_m_cmd got %b/%h want 0/0", m_cmd_vld, m_cmd); else pass_cnt++;
        chk_cnt++; if (req_rdy !== 4'b0 || rsp_vld !== 4'b0) $display("FAIL rm_rdy_vld got %b/%b want 0000/0000", req_rdy, rsp_vld); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 8'h00) $display("FAIL rm_rsp_data got %h want 00", rsp_data); else pass_cnt++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk_cnt++; if (rsp_vld_q.size() !== 0) $display("FAIL rm_no_rsp got %0d want 0", rsp_vld_q.size()); else pass_cnt++;
        clear_logs(); slv_wait = 0;
        set_cmd(0, {1'b0, 8'h05, 8'h00});
        req_vld = 4'b1001;
        wait_gnts(2, 40);
        repeat (10) tick();
        chk_cnt++; if (gnt_q[0] !== 0) $display("FAIL rm_next_grant got %0d want 0", gnt_q[0]); else pass_cnt++;
        chk_cnt++; if (gnt_q[1] !== 3) $display("FAIL rm_second_grant got %0d want 3", gnt_q[1]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_write_then_wait();
        test_wr_ack();
        test_back_to_back();
        test_hold_low();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/apb_cmd_arb.md
Name: apb_cmd_arb

Overview:
- Round-robin arbiter that shares one APB master command port (apb_tx) between NUM_REQ requesters.
- Accepts one command at a time and forwards it downstream with the same {pwrite, paddr, pwdata} packing.
- Holds the grant until the APB transfer completes, then routes read data back to the owning requester.
- Sits between the bus clients and apb_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BW, 8, data width.
- ADDR_BW, 8, address width.
- CMD_BW, DATA_BW+ADDR_BW+1, command width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_cmd  in  NUM_REQ*CMD_BW  flattened commands; requester i occupies bits [i*CMD_BW +: CMD_BW]. Each command is {pwrite, addr, wdata}.
- req_vld  in  NUM_REQ  per-requester command valid.
- req_rdy  out  NUM_REQ  per-requester accept; one-hot or zero.
- rsp_vld  out  NUM_REQ  per-requester response pulse; one-hot or zero.
- rsp_data  out  DATA_BW  read data, valid when rsp_vld is non-zero.
- m_cmd  out  CMD_BW  command to apb_tx.
- m_cmd_vld  out  1  command valid to apb_tx.
- m_cmd_rdy  in  1  apb_tx ready; low while a transfer is in flight.
- m_read_data  in  DATA_BW  apb_tx read data.
- m_read_vld  in  1  apb_tx read completion.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, cmd_r=0, m_cmd_vld=0, req_rdy=0, rsp_vld=0, rsp_data=0.
- State IDLE:
  - req_rdy[w]=1 combinationally for winner w = first i with req_vld[i]=1, scanning from rr_ptr upward with wrap.
  - If any req_vld is set: cmd_r<=req_cmd slice w, owner<=w, state->SEND.
  - If none is set: req_rdy=0 and state stays IDLE.
- State SEND:
  - m_cmd_vld=1 and m_cmd=cmd_r; both held stable until the fire.
  - On m_cmd_vld && m_cmd_rdy: state->WAIT.
- State WAIT:
  - m_cmd_vld=0 and req_rdy=0.
  - The first cycle after the fire (apb_tx SEL phase) always has m_cmd_rdy=0.
  - Exit when m_cmd_rdy=1 is sampled: rr_ptr<=owner+1 (wraps to 0 after NUM_REQ-1), state->IDLE.
- Read response:
  - When m_read_vld=1 in WAIT: next cycle rsp_vld[owner]=1 for exactly one cycle, and rsp_data<=m_read_data.
  - rsp_data holds its value until the next capture.
  - m_read_vld outside WAIT is ignored.
- Write transfers produce no rsp_vld unless WR_ACK_EN is defined.
- Throughput and latency:
  - Minimum of 5 cycles per transaction (IDLE accept, SEND, apb_tx SEL, ACCE, WAIT-exit); no pipelining, one transaction outstanding.
  - Grant-to-m_cmd_vld latency is 1 cycle.
- Fairness: a requester that completes a transfer gets lowest priority on the next arbitration. Any continuously asserted req_vld is granted within NUM_REQ transactions.
- Simultaneous events:
  - A req_vld that rises while the arbiter is in SEND or WAIT waits for IDLE.
  - A requester deasserting req_vld after its grant does not affect the latched cmd_r.
- Reset mid-operation: everything returns to the reset values; the in-flight transaction is dropped without a response. apb_tx shares rst_n.
- m_cmd_rdy held low indefinitely keeps the arbiter in SEND or WAIT; there is no timeout.

Optional Feature:
- Macro: APB_ARB_WR_ACK_EN.
- Defined: on exit from WAIT for a write command (cmd_r[CMD_BW-1]=1), rsp_vld[owner] pulses for one cycle, with rsp_data=0.
- Undefined: writes complete silently; only reads generate rsp_vld.

Decomposition:
- Shared package apb_pkg:
  - State encodings IDLE=2'b00, SEND=2'b01, WAIT=2'b10.
  - CMD_BW derivation and the pwrite bit-index constant.
  - Function clog2 for the owner and rr_ptr widths.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and the pointer; outputs are a one-hot grant, the index and any_vld. It is reusable in other arbiters.

Test Plan:
- Single read: req_vld=4'b0010, cmd={0,8'h3C,8'h00}, slave returns 8'hA5 with pready after 2 wait cycles -> m_cmd=17'h03C00, rsp_vld=4'b0010 for one cycle, rsp_data=8'hA5.
- All four requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with no req_rdy overlap.
- Requester 2 writes 8'h5A to 8'h10 while requester 0 waits -> after the write completes, requester 0 is granted next, with rr_ptr=3.
- Back-to-back, m_cmd_rdy asserted and pready=1 immediately -> spacing of m_cmd_vld fires is 5 cycles. With m_cmd_rdy held low for 10 cycles in SEND, m_cmd stays constant.
- Reset asserted in WAIT during a read from requester 3 -> all outputs return to 0, no rsp_vld, and the next grant starts from requester 0.
- With APB_ARB_WR_ACK_EN, a write by requester 1 -> rsp_vld=4'b0010 for one cycle on WAIT exit. Without the macro -> no rsp_vld.
